// File: rtl/issue_scoreboard.sv
// Decode-to-execute issue controller: 32-entry pending-register scoreboard, in-flight limit,
// one-entry valid/ready issue register. Optional macro ISSUE_WB_BYPASS_EN lets a same-cycle retire unblock hazards.
module issue_scoreboard #(
  parameter int MAX_INFLIGHT = 4,
  parameter int CNT_W        = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_inst,
  input  logic [4:0]       in_rs,
  input  logic [4:0]       in_rs2,
  input  logic [4:0]       in_rd,
  input  logic             in_use_rs,
  input  logic             in_use_rs2,
  input  logic             in_wb,
  output logic             issue_valid,
  input  logic             issue_ready,
  output logic [31:0]      issue_inst,
  output logic [4:0]       issue_rd,
  output logic             issue_wb,
  input  logic             retire_valid,
  input  logic             retire_wb,
  input  logic [4:0]       retire_rd,
  output logic [CNT_W-1:0] inflight,
  output logic             stall_hazard,
  output logic             stall_full
);

  logic [31:0]      pending_q, pending_d;
  logic [CNT_W-1:0] inflight_q, inflight_d;
  logic             issue_valid_q, issue_valid_d;
  logic [31:0]      issue_inst_q, issue_inst_d;
  logic [4:0]       issue_rd_q, issue_rd_d;
  logic             issue_wb_q, issue_wb_d;

  logic [31:0] set_mask, clr_mask, pend_view;
  logic        retire_eff, hazard, full, slot_free, accept;

  // A retire with nothing in flight must not wrap the counter.
  assign retire_eff = retire_valid && (inflight_q != '0);
  assign clr_mask   = (retire_valid && retire_wb && retire_rd != 5'd0) ? (32'd1 << retire_rd) : 32'd0;
  assign set_mask   = (accept && in_wb && in_rd != 5'd0) ? (32'd1 << in_rd) : 32'd0;

`ifdef ISSUE_WB_BYPASS_EN
  assign pend_view = pending_q & ~clr_mask;
  assign full      = ((inflight_q - CNT_W'(retire_eff)) == CNT_W'(MAX_INFLIGHT));
`else
  assign pend_view = pending_q;
  assign full      = (inflight_q == CNT_W'(MAX_INFLIGHT));
`endif

  assign hazard = (in_use_rs  && in_rs  != 5'd0 && pend_view[in_rs])  ||
                  (in_use_rs2 && in_rs2 != 5'd0 && pend_view[in_rs2]) ||
                  (in_wb      && in_rd  != 5'd0 && pend_view[in_rd]);

  assign slot_free    = !issue_valid_q || issue_ready;
  assign in_ready     = slot_free && !hazard && !full && !flush;
  assign accept       = in_valid && in_ready;
  assign stall_hazard = in_valid && hazard;
  assign stall_full   = in_valid && full && !hazard;

  always_comb begin
    issue_valid_d = issue_valid_q;
    issue_inst_d  = issue_inst_q;
    issue_rd_d    = issue_rd_q;
    issue_wb_d    = issue_wb_q;
    // Set applied after clear so a same-cycle set of the same bit wins.
    pending_d     = (pending_q & ~clr_mask) | set_mask;
    inflight_d    = inflight_q + CNT_W'(accept) - CNT_W'(retire_eff);
    if (accept) begin
      issue_valid_d = 1'b1;
      issue_inst_d  = in_inst;
      issue_rd_d    = in_rd;
      issue_wb_d    = in_wb;
    end else if (issue_ready) begin
      issue_valid_d = 1'b0;
    end
    if (flush) begin
      issue_valid_d = 1'b0;
      pending_d     = '0;
      inflight_d    = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issue_valid_q <= 1'b0;
      issue_inst_q  <= '0;
      issue_rd_q    <= '0;
      issue_wb_q    <= 1'b0;
      pending_q     <= '0;
      inflight_q    <= '0;
    end else begin
      issue_valid_q <= issue_valid_d;
      issue_inst_q  <= issue_inst_d;
      issue_rd_q    <= issue_rd_d;
      issue_wb_q    <= issue_wb_d;
      pending_q     <= pending_d;
      inflight_q    <= inflight_d;
    end
  end

  assign issue_valid = issue_valid_q;
  assign issue_inst  = issue_inst_q;
  assign issue_rd    = issue_rd_q;
  assign issue_wb    = issue_wb_q;
  assign inflight    = inflight_q;

endmodule

// File: tb/tb_issue_scoreboard.sv
// Randomized bench for issue_scoreboard: reference model of the scoreboard rules plus a queue of
// accepted instructions that a monitor pops whenever execute takes one from the issue register.
module tb_issue_scoreboard;
  localparam int MAX   = 4;
  localparam int CNT_W = 4;

  logic clk, rst_n, flush, in_valid, in_ready, in_use_rs, in_use_rs2, in_wb;
  logic [31:0] in_inst, issue_inst;
  logic [4:0] in_rs, in_rs2, in_rd, issue_rd, retire_rd;
  logic issue_valid, issue_ready, issue_wb, retire_valid, retire_wb, stall_hazard, stall_full;
  logic [CNT_W-1:0] inflight;

  issue_scoreboard #(.MAX_INFLIGHT(MAX), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_inst(in_inst), .in_rs(in_rs), .in_rs2(in_rs2), .in_rd(in_rd), .in_use_rs(in_use_rs),
    .in_use_rs2(in_use_rs2), .in_wb(in_wb), .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_inst(issue_inst), .issue_rd(issue_rd), .issue_wb(issue_wb), .retire_valid(retire_valid),
    .retire_wb(retire_wb), .retire_rd(retire_rd), .inflight(inflight),
    .stall_hazard(stall_hazard), .stall_full(stall_full));

  typedef struct {
    logic [31:0] inst;
    logic [4:0]  rd;
    logic        wb;
  } item_t;

  item_t exp_q[$];
  int    n_checks = 0;
  int    n_fail   = 0;
  bit    started  = 0;

  // Reference state: set of pending registers, in-flight count, issue slot occupancy.
  bit m_pend[32];
  int m_infl;
  bit m_valid;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    foreach (m_pend[i]) m_pend[i] = 0;
    m_infl  = 0;
    m_valid = 0;
    exp_q.delete();
  endtask

  // Monitor: every execute handshake must match the oldest accepted instruction.
  always @(negedge clk) begin
    if (started && rst_n) begin
      check("issue_valid", {31'd0, issue_valid}, {31'd0, exp_q.size() != 0});
      if (issue_valid && issue_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL issue_pop: got unexpected instruction %0h expected none", issue_inst);
        end else begin
          item_t e;
          e = exp_q.pop_front();
          $display("issue inst=%08h rd=%0d wb=%0b", issue_inst, issue_rd, issue_wb);
          check("issue_inst", issue_inst, e.inst);
          check("issue_rd", {27'd0, issue_rd}, {27'd0, e.rd});
          check("issue_wb", {31'd0, issue_wb}, {31'd0, e.wb});
        end
      end
    end
  end

  function automatic bit busy(input logic use_it, input logic [4:0] r, input logic rv,
                              input logic rwb, input logic [4:0] rrd);
    bit p;
    p = use_it && r != 0 && m_pend[r];
`ifdef ISSUE_WB_BYPASS_EN
    if (rv && rwb && rrd == r) p = 0;
`endif
    return p;
  endfunction

  task automatic drive_random(input int rp, input int rdy_p);
    in_valid     = $urandom_range(0, 99) < 75;
    in_inst      = $urandom;
    in_rs        = 5'($urandom_range(0, 7));
    in_rs2       = 5'($urandom_range(0, 7));
    in_rd        = 5'($urandom_range(0, 7));
    in_use_rs    = $urandom_range(0, 99) < 60;
    in_use_rs2   = $urandom_range(0, 99) < 40;
    in_wb        = $urandom_range(0, 99) < 70;
    issue_ready  = $urandom_range(0, 99) < rdy_p;
    retire_valid = $urandom_range(0, 99) < rp;
    retire_wb    = $urandom_range(0, 99) < 80;
    retire_rd    = 5'($urandom_range(0, 7));
    flush        = $urandom_range(0, 99) < 3;
  endtask

  initial begin
    bit hz, full, exp_ready, acc, clr_q;
    int eff_infl;
    item_t it;
    rst_n = 0; flush = 0; in_valid = 0; in_inst = 0; in_rs = 0; in_rs2 = 0; in_rd = 0;
    in_use_rs = 0; in_use_rs2 = 0; in_wb = 0; issue_ready = 0;
    retire_valid = 0; retire_wb = 0; retire_rd = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_issue_valid", {31'd0, issue_valid}, 32'd0);
    check("rst_issue_inst", issue_inst, 32'd0);
    check("rst_issue_rd", {27'd0, issue_rd}, 32'd0);
    check("rst_issue_wb", {31'd0, issue_wb}, 32'd0);
    check("rst_inflight", {28'd0, inflight}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    rst_n   = 1;
    started = 1;
    drive_random(30, 80);

    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      #1;
      hz = busy(in_use_rs, in_rs, retire_valid, retire_wb, retire_rd) ||
           busy(in_use_rs2, in_rs2, retire_valid, retire_wb, retire_rd) ||
           busy(in_wb, in_rd, retire_valid, retire_wb, retire_rd);
      eff_infl = m_infl;
`ifdef ISSUE_WB_BYPASS_EN
      if (retire_valid && m_infl > 0) eff_infl = m_infl - 1;
`endif
      full      = (eff_infl == MAX);
      exp_ready = (!m_valid || issue_ready) && !hz && !full && !flush;
      check("in_ready", {31'd0, in_ready}, {31'd0, exp_ready});
      check("stall_hazard", {31'd0, stall_hazard}, {31'd0, in_valid && hz});
      check("stall_full", {31'd0, stall_full}, {31'd0, in_valid && full && !hz});
      check("inflight", {28'd0, inflight}, m_infl);
      if (!rst_n) check("rst_mid_inst", issue_inst, 32'd0);

      acc   = rst_n && in_valid && exp_ready;
      clr_q = 0;
      if (rst_n) begin
        if (flush) begin
          foreach (m_pend[i]) m_pend[i] = 0;
          m_infl  = 0;
          m_valid = 0;
          clr_q   = 1;
        end else begin
          if (retire_valid && retire_wb && retire_rd != 0) m_pend[retire_rd] = 0;
          if (acc && in_wb && in_rd != 0) m_pend[in_rd] = 1;
          if (retire_valid && m_infl > 0) m_infl--;
          if (acc) m_infl++;
          m_valid = acc ? 1'b1 : (issue_ready ? 1'b0 : m_valid);
        end
      end
      it.inst = in_inst;
      it.rd   = in_rd;
      it.wb   = in_wb;

      @(posedge clk);
      if (clr_q) exp_q.delete();
      if (acc) exp_q.push_back(it);
      #1;
      rst_n = 1;
      if (cyc < 1000)      drive_random(30, 80);
      else if (cyc < 2000) drive_random(8, 90);
      else                 drive_random(50, 40);
      if (cyc == 1500) begin
        rst_n = 0;
        model_reset();
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/issue_scoreboard.md
Name: issue_scoreboard

Overview:
- Decode-to-execute issue controller for the in-order RISC-V pipeline.
- Accepts one decoded instruction per cycle from the decoder outputs (register indices, writeback flag, operand-use flags).
- Tracks pending destination registers in a 32-entry scoreboard and stalls on RAW/WAW hazards or when the in-flight limit is reached.
- Holds the issued instruction in a one-entry valid/ready output register feeding execute; clears pending bits on retire.

Parameters:
MAX_INFLIGHT, 4, maximum issued-but-not-retired instructions (1..15)
CNT_W, 4, in-flight counter width; must hold MAX_INFLIGHT

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
flush  input  1  synchronous pipeline flush, highest priority
in_valid  input  1  decoded instruction present
in_ready  output  1  instruction accepted this cycle when in_valid&&in_ready
in_inst  input  32  raw instruction word
in_rs  input  5  source register 1
in_rs2  input  5  source register 2
in_rd  input  5  destination register
in_use_rs  input  1  instruction reads rs
in_use_rs2  input  1  instruction reads rs2 (R-type, store, branch)
in_wb  input  1  instruction writes rd (decoder is_writeback)
issue_valid  output  1  issue register holds instruction
issue_ready  input  1  execute accepts
issue_inst  output  32  registered instruction
issue_rd  output  5  registered rd
issue_wb  output  1  registered writeback flag
retire_valid  input  1  one instruction completed (any type)
retire_wb  input  1  completing instruction wrote a register
retire_rd  input  5  its destination
inflight  output  CNT_W  issued-not-retired count
stall_hazard  output  1  in_valid blocked by scoreboard
stall_full  output  1  in_valid blocked by in-flight limit

Behaviour:
- Reset (rst_n low, async): issue_valid=0, issue_inst=0, issue_rd=0, issue_wb=0, pending=0, inflight=0. All other outputs are combinational from this state.
- Hazard (comb): (in_use_rs && in_rs!=0 && pending[in_rs]) || (in_use_rs2 && in_rs2!=0 && pending[in_rs2]) || (in_wb && in_rd!=0 && pending[in_rd]).
- full = (inflight == MAX_INFLIGHT).
- slot_free = !issue_valid || issue_ready.
- in_ready = slot_free && !hazard && !full && !flush. in_ready does not depend on in_valid.
- stall_hazard = in_valid && hazard. stall_full = in_valid && full && !hazard.
- Accept (in_valid && in_ready):
  - Next cycle issue_valid=1 with the captured fields; latency 1 cycle.
  - Set pending[in_rd] if in_wb && in_rd!=0.
  - inflight += 1.
- Issue register update:
  - If issue_valid && issue_ready and no accept, issue_valid=0.
  - If issue_valid && !issue_ready, all issue_* outputs hold stable.
- Retire (retire_valid):
  - Clear pending[retire_rd] if retire_wb && retire_rd!=0.
  - inflight -= 1. A retire when inflight==0 is ignored (no underflow).
- Simultaneous events:
  - Accept and retire in the same cycle leaves inflight unchanged.
  - Set and clear of the same pending bit in one cycle: set wins.
- x0 is never marked pending.
- flush: next cycle issue_valid=0, pending=0, inflight=0. Same-cycle accept and retire are discarded.
- Reset mid-operation discards all state immediately.

Optional Feature:
- Macro: ISSUE_WB_BYPASS_EN.
- Defined: a pending register being cleared by retire in the current cycle (retire_valid && retire_wb && retire_rd==reg) does not count toward hazard, so a dependent instruction issues in the same cycle as the producer's retire. A full stall is still evaluated against the current inflight plus retire, i.e. full = (inflight - retire_valid == MAX_INFLIGHT).
- Undefined: the hazard uses only the registered pending bits, so a dependent instruction issues one cycle after retire.

Test Plan:
- Reset then in_valid with rd=5, wb=1, issue_ready=1 -> in_ready=1; next cycle issue_valid=1, issue_rd=5, pending[5]=1, inflight=1.
- rd=5 pending, then an instruction with rs=5, use_rs=1 -> stall_hazard=1, in_ready=0. Apply retire_valid, retire_wb=1, retire_rd=5 -> accepted the next cycle; with ISSUE_WB_BYPASS_EN it is accepted in the retire cycle.
- Instruction with rd=0, wb=1 then an instruction reading rs=0 -> no stall; pending stays 0.
- Issue 4 independent instructions with no retire (MAX_INFLIGHT=4) -> 5th sees stall_full=1, inflight=4. One retire -> inflight=3 and the 5th is accepted.
- issue_ready=0 with issue_valid=1 -> in_ready=0 and issue_inst held constant over 3 cycles. issue_ready=1 with in_valid the same cycle -> back-to-back issue, no bubble.
- pending={3,7}, inflight=2, then flush=1 with in_valid=1 -> next cycle issue_valid=0, pending=0, inflight=0, instruction not captured.
